// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - N-operand forwarding select / interlock scoreboard (optional FWD_STALL_CNT_EN stall counter)
module fwd_scoreboard #(
  parameter int NUM_OPS    = 2,
  parameter int NUM_STAGES = 4,
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 3
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          flush_i,
  input  logic                          issue_valid_i,
  input  logic                          issue_wr_en_i,
  input  logic [REG_ADDR_W-1:0]         issue_wr_reg_i,
  input  logic [SEL_W-1:0]              issue_rdy_stage_i,
  input  logic [NUM_STAGES-1:0]         stage_kill_i,
  input  logic [NUM_OPS-1:0]            src_used_i,
  input  logic [NUM_OPS*REG_ADDR_W-1:0] src_reg_i,
  output logic [NUM_OPS*SEL_W-1:0]      fwd_sel_o,
  output logic                          stall_o,
  output logic [31:0]                   stall_cnt_o,
  input  logic                          stall_cnt_clr_i
);

  localparam logic [SEL_W-1:0] LAST_STAGE = SEL_W'(NUM_STAGES);

  // index s-1 holds the entry currently in pipeline stage s
  logic [NUM_STAGES-1:0] ent_valid;
  logic [REG_ADDR_W-1:0] ent_reg [NUM_STAGES];
  logic [SEL_W-1:0]      ent_rdy [NUM_STAGES];

  logic [SEL_W-1:0]      rdy_clamped;
  logic                  load_en;
  logic [NUM_OPS-1:0]    hazard;

  // out-of-range ready stages fall back to writeback
  always_comb begin
    rdy_clamped = issue_rdy_stage_i;
    if (issue_rdy_stage_i == '0 || issue_rdy_stage_i > LAST_STAGE)
      rdy_clamped = LAST_STAGE;
  end

  assign load_en = issue_valid_i & issue_wr_en_i & ~stall_o & ~flush_i;

  // tag shift register: advances every cycle, killed entries move on as bubbles
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ent_valid <= '0;
      for (int s = 0; s < NUM_STAGES; s++) begin
        ent_reg[s] <= '0;
        ent_rdy[s] <= '0;
      end
    end else if (flush_i) begin
      ent_valid <= '0;
    end else begin
      ent_valid[0] <= load_en;
      ent_reg[0]   <= issue_wr_reg_i;
      ent_rdy[0]   <= rdy_clamped;
      for (int s = 1; s < NUM_STAGES; s++) begin
        ent_valid[s] <= ent_valid[s-1] & ~stage_kill_i[s-1];
        ent_reg[s]   <= ent_reg[s-1];
        ent_rdy[s]   <= ent_rdy[s-1];
      end
    end
  end

  // per-operand youngest-match search; scanning oldest to youngest lets the youngest win
  always_comb begin
    logic                 hit;
    logic [SEL_W-1:0]     hit_stage;
    logic [SEL_W-1:0]     hit_rdy;
    logic [REG_ADDR_W-1:0] src;
    fwd_sel_o = '0;
    hazard    = '0;
    hit       = 1'b0;
    hit_stage = '0;
    hit_rdy   = '0;
    src       = '0;
    for (int o = 0; o < NUM_OPS; o++) begin
      hit       = 1'b0;
      hit_stage = '0;
      hit_rdy   = '0;
      src       = src_reg_i[o*REG_ADDR_W +: REG_ADDR_W];
      for (int s = NUM_STAGES - 1; s >= 0; s--) begin
        if (ent_valid[s] && !stage_kill_i[s] && ent_reg[s] == src) begin
          hit       = 1'b1;
          hit_stage = SEL_W'(s + 1);
          hit_rdy   = ent_rdy[s];
        end
      end
      if (src_used_i[o] && hit && !flush_i) begin
        if (hit_stage >= hit_rdy)
          fwd_sel_o[o*SEL_W +: SEL_W] = hit_stage;
        else
          hazard[o] = 1'b1;
      end
    end
  end

  assign stall_o = |hazard;

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt;

  // saturating stall-cycle counter, clear wins over increment
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      stall_cnt <= '0;
    else if (stall_cnt_clr_i)
      stall_cnt <= '0;
    else if (stall_o && stall_cnt != 32'hFFFF_FFFF)
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign stall_cnt_o = stall_cnt;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = stall_cnt_clr_i;
  assign stall_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - randomized self-checking bench for fwd_scoreboard
module tb_fwd_scoreboard;
  localparam int NO = 2;
  localparam int NS = 4;
  localparam int RW = 5;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            flush = 1'b0;
  logic            issue_valid = 1'b0;
  logic            issue_wr_en = 1'b0;
  logic [RW-1:0]   issue_wr_reg = '0;
  logic [SW-1:0]   issue_rdy = '0;
  logic [NS-1:0]   stage_kill = '0;
  logic [NO-1:0]   src_used = '0;
  logic [NO*RW-1:0] src_reg = '0;
  logic [NO*SW-1:0] fwd_sel;
  logic            stall;
  logic [31:0]     stall_cnt;
  logic            stall_cnt_clr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int rg;
    int rdy;
    int age;
  } rec_t;

  rec_t        q[$];
  int          exp_sel[NO];
  bit          exp_stall;
  logic [31:0] exp_cnt = '0;

  fwd_scoreboard #(
    .NUM_OPS(NO), .NUM_STAGES(NS), .REG_ADDR_W(RW), .SEL_W(SW)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush),
    .issue_valid_i(issue_valid), .issue_wr_en_i(issue_wr_en),
    .issue_wr_reg_i(issue_wr_reg), .issue_rdy_stage_i(issue_rdy),
    .stage_kill_i(stage_kill), .src_used_i(src_used), .src_reg_i(src_reg),
    .fwd_sel_o(fwd_sel), .stall_o(stall), .stall_cnt_o(stall_cnt),
    .stall_cnt_clr_i(stall_cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: list of in-flight writers, each tagged with its age in cycles since issue
  function automatic void model_eval();
    exp_stall = 1'b0;
    for (int o = 0; o < NO; o++) begin
      int src;
      int best;
      int brdy;
      src = int'(src_reg[o*RW +: RW]);
      best = 0;
      brdy = 0;
      foreach (q[i]) begin
        if (!stage_kill[q[i].age-1] && q[i].rg == src && src_used[o] &&
            (best == 0 || q[i].age < best)) begin
          best = q[i].age;
          brdy = q[i].rdy;
        end
      end
      exp_sel[o] = 0;
      if (!flush && best != 0) begin
        if (best >= brdy) exp_sel[o] = best;
        else exp_stall = 1'b1;
      end
    end
  endfunction

  function automatic void model_update();
    rec_t nq[$];
    rec_t r;
    if (stall_cnt_clr) exp_cnt = '0;
    else if (exp_stall && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
`ifndef FWD_STALL_CNT_EN
    exp_cnt = '0;
`endif
    if (flush) begin
      q.delete();
      return;
    end
    foreach (q[i]) begin
      if (stage_kill[q[i].age-1]) continue;
      r = q[i];
      r.age++;
      if (r.age <= NS) nq.push_back(r);
    end
    if (issue_valid && issue_wr_en && !exp_stall) begin
      r.rg  = int'(issue_wr_reg);
      r.rdy = (issue_rdy == 0 || int'(issue_rdy) > NS) ? NS : int'(issue_rdy);
      r.age = 1;
      nq.push_back(r);
    end
    q = nq;
  endfunction

  task automatic settle();
    #3;
  endtask

  task automatic tick();
    model_eval();
    for (int o = 0; o < NO; o++)
      check($sformatf("fwd_sel[%0d]", o), 32'(fwd_sel[o*SW +: SW]), 32'(exp_sel[o]));
    check("stall", 32'(stall), 32'(exp_stall));
    check("stall_cnt", stall_cnt, exp_cnt);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    flush = 0; issue_valid = 0; issue_wr_en = 0; stage_kill = '0;
    src_used = '0; stall_cnt_clr = 0;
  endtask

  task automatic issue(input int rg, input int rdy);
    issue_valid = 1; issue_wr_en = 1;
    issue_wr_reg = RW'(rg); issue_rdy = SW'(rdy);
  endtask

  task automatic use_src(input int o, input int rg);
    src_used[o] = 1'b1;
    src_reg[o*RW +: RW] = RW'(rg);
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < NS + 1; i++) begin
      settle();
      tick();
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_sel", 32'(fwd_sel), 32'd0);
    check("rst_cnt", stall_cnt, 32'd0);
    q.delete();
    exp_cnt = '0;
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    // reset state
    idle();
    #2;
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_sel", 32'(fwd_sel), 32'd0);
    check("reset_cnt", stall_cnt, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // ALU back-to-back
    issue(3, 1); settle(); tick();
    idle(); use_src(0, 3); settle();
    check("alu_sel1", 32'(fwd_sel[0 +: SW]), 32'd1);
    check("alu_nostall", 32'(stall), 32'd0);
    tick(); settle();
    check("alu_sel2", 32'(fwd_sel[0 +: SW]), 32'd2);
    tick();

    // load-use with an issue attempt held off during the stall
    drain();
    issue(5, 3); settle(); tick();
    idle(); use_src(1, 5); issue(6, 1); settle();
    check("lu_stall_s1", 32'(stall), 32'd1);
    tick(); settle();
    check("lu_stall_s2", 32'(stall), 32'd1);
    tick(); use_src(0, 6); settle();
    check("lu_sel3", 32'(fwd_sel[SW +: SW]), 32'd3);
    check("lu_go", 32'(stall), 32'd0);
    check("lu_bubble", 32'(fwd_sel[0 +: SW]), 32'd0);
    tick();

    // youngest match wins
    drain();
    issue(7, 1); settle(); tick();
    issue(7, 1); settle(); tick();
    idle(); use_src(0, 7); settle();
    check("young_sel", 32'(fwd_sel[0 +: SW]), 32'd1);
    tick();

    // kill in stage 2
    drain();
    issue(4, 1); settle(); tick();
    idle(); settle(); tick();
    use_src(0, 4); stage_kill = 4'b0010; settle();
    check("kill_sel", 32'(fwd_sel[0 +: SW]), 32'd0);
    check("kill_stall", 32'(stall), 32'd0);
    tick();
    stage_kill = '0; settle();
    check("kill_after", 32'(fwd_sel[0 +: SW]), 32'd0);
    tick();

    // flush mid-stall
    drain();
    issue(9, 4); settle(); tick();
    idle(); use_src(0, 9); settle();
    check("fl_stall", 32'(stall), 32'd1);
    flush = 1; #1;
    check("fl_nostall", 32'(stall), 32'd0);
    check("fl_sel", 32'(fwd_sel), 32'd0);
    tick();
    flush = 0; settle();
    check("fl_empty", 32'(stall), 32'd0);
    tick();

    // async reset mid-stall
    drain();
    issue(9, 4); settle(); tick();
    idle(); use_src(0, 9); settle();
    check("rs_stall", 32'(stall), 32'd1);
    do_reset();
    settle(); tick();

    // randomized traffic against the reference list
    for (int c = 0; c < 3000; c++) begin
      issue_valid   = ($urandom % 4) != 0;
      issue_wr_en   = ($urandom % 4) != 0;
      issue_wr_reg  = RW'($urandom % 4);
      issue_rdy     = SW'($urandom % 8);
      for (int s = 0; s < NS; s++) stage_kill[s] = ($urandom % 10) == 0;
      src_used      = NO'($urandom);
      for (int o = 0; o < NO; o++) src_reg[o*RW +: RW] = RW'($urandom % 4);
      flush         = ($urandom % 20) == 0;
      stall_cnt_clr = ($urandom % 50) == 0;
      if (($urandom % 300) == 0) do_reset();
      settle();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
